l2_arb_slot_scheduler: RTL and testbench
========================================

// Module: l2_arb_slot_scheduler
//
// PURPOSE
// Decides which source owns the single L2 pipeline issue slot each cycle:
// the restarted-request path from the L2 bus interface or one of the core
// request ports. Restarts normally take precedence. A starvation counter
// forces a bounded run of core slots when cores are shut out too long.
// Round-robin selection among cores; sits in front of the L2 arb stage.
//
// PARAMETERS
// NUM_REQUESTERS  4   number of core request ports (>= 1)
// STARVE_LIMIT    16  consecutive lost core slots before forcing (>= 1)
// FORCE_SLOTS     2   core slots granted per forced episode (>= 1)
//
// PORTS
// clk              in   1               clock
// reset            in   1               asynchronous, active-high reset
// core_request     in   NUM_REQUESTERS  per-core request valid
// restart_pending  in   1               restarted request waiting (bus interface)
// bus_stall        in   1               downstream cannot accept any request
// grant_oh         out  NUM_REQUESTERS  one-hot winning core (0 if none)
// core_accept      out  1               core named by grant_oh issues this cycle
// restart_accept   out  1               restarted request issues this cycle
// force_active     out  1               state == FORCE_CORE
// perf_force_event out  1               1-cycle pulse on entering FORCE_CORE
//
// BEHAVIOUR
// - Reset (async): rr_ptr=0, state=NORMAL, starve_cnt=0, force_cnt=0,
//   perf_force_event=0. Comb outputs settle from those values.
// - grant_oh (comb): first set bit of core_request at or above rr_ptr,
//   wrapping at NUM_REQUESTERS-1 -> 0; all zero if core_request==0.
// - NORMAL: restart_accept = restart_pending & !bus_stall;
//   core_accept = |core_request & !restart_pending & !bus_stall.
// - FORCE_CORE: restart_accept = 0;
//   core_accept = |core_request & !bus_stall.
// - Outputs exactly one of core_accept/restart_accept or neither; never both.
// - Zero latency: accepts are combinational from inputs and state. Inputs
//   must not depend on any output (no comb loop).
// - rr_ptr: on core_accept, rr_ptr <= (granted idx + 1) mod NUM_REQUESTERS;
//   held otherwise, including during bus_stall.
// - starve_cnt (NORMAL only): "lost" cycle = |core_request & restart_pending
//   & !bus_stall. Lost -> +1. core_accept or core_request==0 -> 0.
//   bus_stall -> hold.
// - NORMAL->FORCE_CORE when a lost cycle occurs with starve_cnt==STARVE_LIMIT-1:
//   starve_cnt<=0, force_cnt<=FORCE_SLOTS, perf_force_event<=1 next cycle.
// - FORCE_CORE: each core_accept decrements force_cnt; return to NORMAL after
//   the accept that takes force_cnt 1->0. If core_request==0, return to NORMAL
//   next cycle with force_cnt<=0 (abandon the episode). bus_stall holds state.
// - starve_cnt width $clog2(STARVE_LIMIT+1); force_cnt $clog2(FORCE_SLOTS+1).
//   Neither wraps.
// - NUM_REQUESTERS==1: grant_oh = core_request; rr_ptr is constant 0.
// - Reset asserted mid-episode: FORCE_CORE is abandoned immediately;
//   restarts are eligible in the first cycle after reset is released.
//
// TESTING
// 1 core_request=4'b0101, no restart, no stall, 4 cycles -> grant_oh
//   0001,0100,0001,0100; core_accept=1 each cycle.
// 2 restart_pending=1 held, core_request=0001 -> restart_accept=1 for 16 cycles;
//   cycle 17 force_active=1, perf_force_event pulses, core_accept=1 x2,
//   restart_accept=0; then NORMAL.
// 3 Scenario 2 with bus_stall=1 for cycles 5-9 -> force entered at cycle 22
//   (stalled cycles neither count nor reset starve_cnt).
// 4 In FORCE_CORE, drop core_request after 1 accept -> NORMAL next cycle,
//   restart_accept=1.
// 5 Assert reset in FORCE_CORE with rr_ptr=2 -> force_active=0, rr_ptr=0,
//   grant_oh lowest set bit after release.
// 6 Every cycle, random stimulus -> grant_oh onehot0; !(core_accept &
//   restart_accept); no accept while bus_stall=1.

Source files
------------

// File: rtl/l2_arb_slot_scheduler_if.sv
// Issue-slot arbitration bundle between the L2 request sources and the slot scheduler.
// The master side drives requests and stall, and the slave side (the scheduler) returns the grant and accept decisions.
interface l2_arb_slot_scheduler_if #(
   parameter int NUM_REQUESTERS = 4
);
   logic [NUM_REQUESTERS-1:0] core_request;
   logic                      restart_pending;
   logic                      bus_stall;
   logic [NUM_REQUESTERS-1:0] grant_oh;
   logic                      core_accept;
   logic                      restart_accept;
   logic                      force_active;
   logic                      perf_force_event;

   modport master (
      output core_request, restart_pending, bus_stall,
      input  grant_oh, core_accept, restart_accept, force_active, perf_force_event
   );

   modport slave (
      input  core_request, restart_pending, bus_stall,
      output grant_oh, core_accept, restart_accept, force_active, perf_force_event
   );
endinterface

// File: rtl/l2_arb_slot_scheduler.sv
// Picks the owner of the single L2 issue slot: restarted request or a round-robin core.
// Cores that are shut out for too long get a short forced run of slots.
module l2_arb_slot_scheduler #(
   parameter int NUM_REQUESTERS = 4,
   parameter int STARVE_LIMIT   = 16,
   parameter int FORCE_SLOTS    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   l2_arb_slot_scheduler_if.slave bus
);
   localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
   localparam int SW    = $clog2(STARVE_LIMIT + 1);
   localparam int FW    = $clog2(FORCE_SLOTS + 1);

   typedef enum logic {ST_NORMAL = 1'b0, ST_FORCE = 1'b1} state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic [PTR_W-1:0]          r_rr_ptr;
   logic [SW-1:0]             r_starve_cnt;
   logic [FW-1:0]             r_force_cnt;
   logic                      r_perf_force_event;
   logic [NUM_REQUESTERS-1:0] w_grant_oh;
   logic [PTR_W-1:0]          w_grant_idx;
   logic                      w_found;
   logic                      w_any_req;
   logic                      w_lost;
   logic                      w_starve_hit;
   logic                      w_core_accept;
   logic                      w_restart_accept;

   assign w_any_req    = |bus.core_request;
   assign w_lost       = w_any_req & bus.restart_pending & ~bus.bus_stall;
   assign w_starve_hit = (r_starve_cnt == SW'(STARVE_LIMIT - 1));

   // Rotating priority search starting at r_rr_ptr.
   always_comb begin
      w_grant_oh  = '0;
      w_grant_idx = '0;
      w_found     = 1'b0;
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
         if (!w_found && bus.core_request[(int'(r_rr_ptr) + k) % NUM_REQUESTERS]) begin
            w_found     = 1'b1;
            w_grant_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQUESTERS);
            w_grant_oh[(int'(r_rr_ptr) + k) % NUM_REQUESTERS] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_NORMAL;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_NORMAL: if (w_lost && w_starve_hit) w_state_next = ST_FORCE;
         ST_FORCE: begin
            if (!bus.bus_stall && (!w_any_req || r_force_cnt == FW'(1)))
               w_state_next = ST_NORMAL;
         end
         default:   w_state_next = ST_NORMAL;
      endcase
   end

   always_comb begin
      w_restart_accept = 1'b0;
      w_core_accept    = 1'b0;
      case (r_state)
         ST_NORMAL: begin
            w_restart_accept = bus.restart_pending & ~bus.bus_stall;
            w_core_accept    = w_any_req & ~bus.restart_pending & ~bus.bus_stall;
         end
         ST_FORCE: w_core_accept = w_any_req & ~bus.bus_stall;
         default: begin
            w_restart_accept = 1'b0;
            w_core_accept    = 1'b0;
         end
      endcase
   end

   generate
      if (NUM_REQUESTERS > 1) begin : g_rr
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_rr_ptr <= '0;
            end else if (w_core_accept) begin
               r_rr_ptr <= (w_grant_idx == PTR_W'(NUM_REQUESTERS - 1)) ? '0 : w_grant_idx + PTR_W'(1);
            end
         end
      end else begin : g_single
         assign r_rr_ptr = '0;
      end
   endgenerate

   // A stalled cycle neither counts as lost nor clears the starvation history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_starve_cnt       <= '0;
         r_force_cnt        <= '0;
         r_perf_force_event <= 1'b0;
      end else begin
         r_perf_force_event <= (r_state == ST_NORMAL) && (w_state_next == ST_FORCE);
         if (r_state == ST_NORMAL) begin
            if (!bus.bus_stall) begin
               if (w_lost && w_starve_hit) begin
                  r_starve_cnt <= '0;
                  r_force_cnt  <= FW'(FORCE_SLOTS);
               end else if (w_lost) begin
                  r_starve_cnt <= r_starve_cnt + SW'(1);
               end else begin
                  r_starve_cnt <= '0;
               end
            end
         end else if (!bus.bus_stall) begin
            if (!w_any_req) r_force_cnt <= '0;
            else            r_force_cnt <= r_force_cnt - FW'(1);
         end
      end
   end

   assign bus.grant_oh         = w_grant_oh;
   assign bus.core_accept      = w_core_accept;
   assign bus.restart_accept   = w_restart_accept;
   assign bus.force_active     = (r_state == ST_FORCE);
   assign bus.perf_force_event = r_perf_force_event;
endmodule

// File: tb/tb_l2_arb_slot_scheduler.sv
// Bench for the L2 issue-slot scheduler: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a behavioural slot-ownership model.
module tb_l2_arb_slot_scheduler;
   localparam int N  = 4;
   localparam int SL = 16;
   localparam int FS = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   l2_arb_slot_scheduler_if #(.NUM_REQUESTERS(N)) bus_if ();

   l2_arb_slot_scheduler #(
      .NUM_REQUESTERS(N),
      .STARVE_LIMIT  (SL),
      .FORCE_SLOTS   (FS)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who owns the slot, expressed as counts of lost cycles
   // and remaining forced slots.
   int         m_ptr, m_starve, m_left, m_g;
   bit         m_forcing, m_perf, m_perf_next, m_any, m_rp, m_st, m_ec, m_er;
   logic [N-1:0] m_req, m_eg;

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            m_ptr = 0; m_starve = 0; m_left = 0; m_forcing = 0; m_perf = 0;
         end
         m_req = bus_if.core_request;
         m_rp  = bus_if.restart_pending;
         m_st  = bus_if.bus_stall;
         m_any = (m_req != '0);
         m_g   = -1;
         for (int k = 0; k < N; k++)
            if (m_g < 0 && m_req[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
         m_eg = '0;
         if (m_g >= 0) m_eg[m_g] = 1'b1;
         m_er = m_rp && !m_st && !m_forcing;
         m_ec = m_any && !m_st && (m_forcing || !m_rp);

         check("grant_oh",         bus_if.grant_oh,         m_eg);
         check("core_accept",      bus_if.core_accept,      m_ec);
         check("restart_accept",   bus_if.restart_accept,   m_er);
         check("force_active",     bus_if.force_active,     m_forcing);
         check("perf_force_event", bus_if.perf_force_event, m_perf);
         check("grant_onehot0",    $onehot0(bus_if.grant_oh), 1);
         check("accept_exclusive", bus_if.core_accept & bus_if.restart_accept, 0);
         check("no_accept_stall",  m_st & (bus_if.core_accept | bus_if.restart_accept), 0);

         if (!reset) begin
            m_perf_next = 0;
            if (m_ec) m_ptr = (m_g + 1) % N;
            if (!m_st) begin
               if (!m_forcing) begin
                  if (m_any && m_rp) begin
                     m_starve++;
                     if (m_starve == SL) begin
                        m_starve = 0; m_forcing = 1; m_left = FS; m_perf_next = 1;
                     end
                  end else begin
                     m_starve = 0;
                  end
               end else if (!m_any) begin
                  m_forcing = 0; m_left = 0;
               end else begin
                  m_left--;
                  if (m_left == 0) m_forcing = 0;
               end
            end
            m_perf = m_perf_next;
         end
      end
   end

   task automatic step(input logic [N-1:0] req, input bit rp, input bit st);
      @(posedge clk); #1;
      bus_if.core_request    = req;
      bus_if.restart_pending = rp;
      bus_if.bus_stall       = st;
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      bus_if.core_request = '0; bus_if.restart_pending = 0; bus_if.bus_stall = 0;
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   logic [N-1:0] exp_seq [4];

   initial begin
      bus_if.core_request = '0; bus_if.restart_pending = 0; bus_if.bus_stall = 0;
      #2;
      check("reset_force_active", bus_if.force_active, 0);
      check("reset_perf",         bus_if.perf_force_event, 0);
      do_reset();

      // 1: alternating round robin
      exp_seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      for (int i = 0; i < 4; i++) begin
         step(4'b0101, 0, 0);
         $display("s1 cycle %0d grant=%b core_accept=%0b", i + 1, bus_if.grant_oh, bus_if.core_accept);
         check("s1_grant",  bus_if.grant_oh, exp_seq[i]);
         check("s1_accept", bus_if.core_accept, 1);
      end

      // 2: restart stream starves core 0 until a forced pair of slots
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         step(4'b0001, 1, 0);
         check("s2_restart", bus_if.restart_accept, 1);
         check("s2_noforce", bus_if.force_active, 0);
      end
      step(4'b0001, 1, 0);
      $display("s2 cycle 17 force=%0b perf=%0b core_accept=%0b", bus_if.force_active, bus_if.perf_force_event, bus_if.core_accept);
      check("s2_c17_force", bus_if.force_active, 1);
      check("s2_c17_perf",  bus_if.perf_force_event, 1);
      check("s2_c17_core",  bus_if.core_accept, 1);
      check("s2_c17_rst",   bus_if.restart_accept, 0);
      step(4'b0001, 1, 0);
      check("s2_c18_force", bus_if.force_active, 1);
      check("s2_c18_perf",  bus_if.perf_force_event, 0);
      check("s2_c18_core",  bus_if.core_accept, 1);
      step(4'b0001, 1, 0);
      check("s2_c19_force",   bus_if.force_active, 0);
      check("s2_c19_restart", bus_if.restart_accept, 1);

      // 3: stalled cycles 5-9 delay force entry to cycle 22
      do_reset();
      for (int i = 1; i <= 22; i++) begin
         step(4'b0001, 1, (i >= 5 && i <= 9));
         if (i == 21) check("s3_c21_force", bus_if.force_active, 0);
         if (i == 22) begin
            $display("s3 cycle 22 force=%0b perf=%0b", bus_if.force_active, bus_if.perf_force_event);
            check("s3_c22_force", bus_if.force_active, 1);
            check("s3_c22_perf",  bus_if.perf_force_event, 1);
         end
      end

      // 4: request dropped mid-episode abandons the force
      do_reset();
      for (int i = 1; i <= 17; i++) step(4'b0001, 1, 0);
      check("s4_c17_core", bus_if.core_accept, 1);
      step(4'b0000, 1, 0);
      check("s4_c18_force", bus_if.force_active, 1);
      check("s4_c18_core",  bus_if.core_accept, 0);
      step(4'b0000, 1, 0);
      $display("s4 cycle 19 force=%0b restart_accept=%0b", bus_if.force_active, bus_if.restart_accept);
      check("s4_c19_force",   bus_if.force_active, 0);
      check("s4_c19_restart", bus_if.restart_accept, 1);

      // 5: reset while forcing with rr_ptr parked at 2
      do_reset();
      step(4'b0010, 0, 0);
      for (int i = 1; i <= 16; i++) step(4'b0010, 1, 0);
      step(4'b0010, 1, 0);
      check("s5_forcing", bus_if.force_active, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("s5_reset_force", bus_if.force_active, 0);
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      bus_if.core_request = 4'b1111; bus_if.restart_pending = 0; bus_if.bus_stall = 0;
      @(negedge clk); #1;
      $display("s5 after release grant=%b", bus_if.grant_oh);
      check("s5_grant", bus_if.grant_oh, 4'b0001);

      // 6: randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         reset = ($urandom_range(0, 299) == 0);
         bus_if.core_request    = N'($urandom);
         bus_if.restart_pending = ($urandom_range(0, 9) < 8);
         bus_if.bus_stall       = ($urandom_range(0, 9) == 0);
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
